// File: rtl/pla_eval_if.sv
`default_nettype none
// ============================================================================
//  Module      : pla_eval_if
//  Description : Request/response bundle for the PLA evaluation arbiter.
//                - req_valid / req_ready / req_x : NREQ requester lanes,
//                  requester i uses req_x[15i+14:15i].
//                - rsp_valid / rsp_ready / rsp_id / rsp_z : single response
//                  channel with backpressure.
//                The master side drives requests and consumes responses.
//                The slave side is the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pla_eval_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*15-1:0] req_x;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [10:0]        rsp_z;

    modport master (
        output req_valid, req_x, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_z
    );

    modport slave (
        input  req_valid, req_x, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_z
    );
endinterface
`default_nettype wire

// File: rtl/pla_eval_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pla_eval_arbiter
//  Description : Round-robin arbiter/sequencer sharing one combinational
//                15-in/11-out PLA among NREQ requesters. A granted vector is
//                registered onto pla_x, pla_z is captured SETTLE cycles
//                later and returned tagged with the requester id.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                bus (slave)     - request lanes and response channel
//                pla_x  (out 15) - registered PLA input drive
//                pla_z  (in  11) - PLA outputs
//                busy   (out  1) - high whenever not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module pla_eval_arbiter #(
    parameter int NREQ   = 4,
    parameter int SETTLE = 1,
    parameter int IDW    = $clog2(NREQ)
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    pla_eval_if.slave        bus,
    output logic [14:0]      pla_x,
    input  wire logic [10:0] pla_z,
    output logic             busy
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0]    c_IDLE     = 2'd0;
    localparam logic [1:0]    c_EVAL     = 2'd1;
    localparam logic [1:0]    c_RESP     = 2'd2;
    localparam logic [CW-1:0] c_CNT_LOAD = CW'(SETTLE - 1);
    localparam logic [IDW:0]  c_NREQ     = (IDW + 1)'(NREQ);

    logic [1:0]     r_state;
    logic [IDW-1:0] r_ptr;
    logic [CW-1:0]  r_cnt;
    logic [14:0]    r_pla_x;
    logic [10:0]    r_rsp_z;
    logic [IDW-1:0] r_rsp_id;

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic              w_found;
    logic [IDW-1:0]    w_off;
    logic [IDW:0]      w_sum;
    logic [IDW-1:0]    w_gidx;
    logic [IDW:0]      w_nxt;
    logic [IDW-1:0]    w_ptr_nxt;
    logic [14:0]       w_reqx [NREQ];

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_unpack
            assign w_reqx[i] = bus.req_x[15*i +: 15];
        end
    endgenerate

    // Rotate the valid vector so that bit 0 corresponds to ptr; the lowest
    // set bit of the rotated vector is then the round-robin winner offset.
    assign w_dbl = {bus.req_valid, bus.req_valid};
    assign w_rot = NREQ'(w_dbl >> r_ptr);

    always_comb begin
        w_found = |w_rot;
        w_off   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDW'(k);
            end
        end
    end

    // Undo the rotation modulo NREQ (NREQ need not be a power of two).
    assign w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_gidx = (w_sum >= c_NREQ) ? IDW'(w_sum - c_NREQ) : IDW'(w_sum);

    assign w_nxt     = {1'b0, r_rsp_id} + 1'b1;
    assign w_ptr_nxt = (w_nxt == c_NREQ) ? '0 : IDW'(w_nxt);

    // Gated by rst_n so no requester sees an accept while reset is held.
    assign bus.req_ready = (rst_n && (r_state == c_IDLE) && w_found)
                         ? (NREQ'(1) << w_gidx) : '0;

    assign bus.rsp_valid = (r_state == c_RESP);
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_z     = r_rsp_z;
    assign pla_x         = r_pla_x;
    assign busy          = (r_state != c_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_pla_x  <= '0;
            r_rsp_z  <= '0;
            r_rsp_id <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_pla_x  <= w_reqx[w_gidx];
                        r_rsp_id <= w_gidx;
                        r_cnt    <= c_CNT_LOAD;
                        r_state  <= c_EVAL;
                    end
                end
                c_EVAL: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_rsp_z <= pla_z;
                        r_state <= c_RESP;
                    end
                end
                c_RESP: begin
                    if (bus.rsp_ready) begin
                        r_ptr   <= w_ptr_nxt;
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pla_eval_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pla_eval_arbiter
//  Description : Self-checking bench for pla_eval_arbiter. One instance with
//                SETTLE=1 is tracked cycle by cycle against a transaction
//                level reference model; a second with SETTLE=4 exercises the
//                long settle path. Stub PLAs return pla_x[10:0].
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pla_eval_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int S1   = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pla_eval_if #(.NREQ(NREQ), .IDW(IDW)) bus1 ();
    pla_eval_if #(.NREQ(NREQ), .IDW(IDW)) bus4 ();

    logic [14:0] pla_x1, pla_x4;
    logic [10:0] pla_z1, pla_z4;
    logic        busy1, busy4;
    logic [10:0] z4_xor = '0;

    assign pla_z1 = pla_x1[10:0];
    assign pla_z4 = pla_x4[10:0] ^ z4_xor;

    pla_eval_arbiter #(.NREQ(NREQ), .SETTLE(S1), .IDW(IDW)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
        .pla_x(pla_x1), .pla_z(pla_z1), .busy(busy1)
    );

    pla_eval_arbiter #(.NREQ(NREQ), .SETTLE(4), .IDW(IDW)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4.slave),
        .pla_x(pla_x4), .pla_z(pla_z4), .busy(busy4)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Requester-side state for dut1.
    bit          rv [NREQ];
    logic [14:0] rx [NREQ];

    // Transaction-level reference model.
    bit          m_busy, m_rspv;
    int          m_id, m_ptr, m_cap, m_hs, cyc;
    logic [14:0] m_x;
    logic [10:0] m_z;

    function automatic int m_winner();
        for (int k = 0; k < NREQ; k++) begin
            if (rv[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_rspv = 0; m_id = 0; m_ptr = 0;
        m_x = '0; m_z = '0; m_hs = -1;
    endtask

    task automatic model_edge();
        int w;
        m_hs = -1;
        if (!m_busy) begin
            w = m_winner();
            if (w >= 0) begin
                m_busy = 1; m_id = w; m_x = rx[w]; m_cap = cyc + S1; m_hs = w;
            end
        end else if (!m_rspv) begin
            if (cyc == m_cap) begin
                m_z = m_x[10:0];
                m_rspv = 1;
            end
        end else if (bus1.rsp_ready) begin
            m_busy = 0; m_rspv = 0;
            m_ptr = (m_id + 1) % NREQ;
        end
    endtask

    task automatic apply_reqs();
        for (int i = 0; i < NREQ; i++) begin
            bus1.req_valid[i]      = rv[i];
            bus1.req_x[15*i +: 15] = rx[i];
        end
    endtask

    task automatic check_outputs();
        int w;
        logic [NREQ-1:0] e_rdy;
        e_rdy = '0;
        w = m_busy ? -1 : m_winner();
        if (w >= 0) e_rdy[w] = 1'b1;
        chk_val("req_ready", bus1.req_ready, e_rdy);
        chk_val("busy", busy1, m_busy);
        chk_val("rsp_valid", bus1.rsp_valid, m_rspv);
        chk_val("pla_x", pla_x1, m_x);
        chk_val("rsp_id", bus1.rsp_id, m_id);
        chk_val("rsp_z", bus1.rsp_z, m_z);
    endtask

    // Entered and left at a falling edge.
    task automatic settle();
        apply_reqs();
        #1;
    endtask

    task automatic step();
        settle();
        check_outputs();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) rv[i] = 0;
    endtask

    task automatic drain();
        bus1.rsp_ready = 1'b1;
        for (int n = 0; n < 20 && m_busy; n++) step();
        chk_val("drain timeout", m_busy, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_val("rst busy1", busy1, 0);
        chk_val("rst rsp_valid1", bus1.rsp_valid, 0);
        chk_val("rst req_ready1", bus1.req_ready, 0);
        chk_val("rst pla_x1", pla_x1, 0);
        chk_val("rst rsp_id1", bus1.rsp_id, 0);
        chk_val("rst rsp_z1", bus1.rsp_z, 0);
        chk_val("rst busy4", busy4, 0);
        chk_val("rst rsp_valid4", bus4.rsp_valid, 0);
        chk_val("rst pla_x4", pla_x4, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_long_settle(input logic [10:0] xv, input logic [10:0] exp_z);
        bus4.req_valid = 4'b0001;
        bus4.req_x     = '0;
        bus4.req_x[14:0] = 15'h7FFF;
        bus4.rsp_ready = 1'b1;
        z4_xor = '0;
        #1 chk_val("ls req_ready", bus4.req_ready, 4'b0001);
        @(posedge clk); @(negedge clk);
        bus4.req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk_val("ls pla_x", pla_x4, 15'h7FFF);
            chk_val("ls early rsp_valid", bus4.rsp_valid, 0);
            chk_val("ls busy", busy4, 1);
            @(posedge clk); @(negedge clk);
        end
        z4_xor = xv;
        #1 chk_val("ls rsp_valid before capture", bus4.rsp_valid, 0);
        @(posedge clk); @(negedge clk);
        #1;
        chk_val("ls rsp_valid", bus4.rsp_valid, 1);
        chk_val("ls rsp_z", bus4.rsp_z, exp_z);
        chk_val("ls rsp_id", bus4.rsp_id, 0);
        @(posedge clk); @(negedge clk);
        #1;
        chk_val("ls done rsp_valid", bus4.rsp_valid, 0);
        chk_val("ls done busy", busy4, 0);
        z4_xor = '0;
        @(negedge clk);
    endtask

    initial begin
        int nresp, last, exp_id;
        cyc = 0;
        for (int i = 0; i < NREQ; i++) begin rv[i] = 0; rx[i] = '0; end
        bus1.rsp_ready = 1'b0;
        bus4.req_valid = '0; bus4.req_x = '0; bus4.rsp_ready = 1'b0;
        apply_reqs();
        @(negedge clk);
        do_reset();

        // Long settle on the SETTLE=4 instance, with and without a late pla_z change.
        test_long_settle(11'h000, 11'h7FF);
        test_long_settle(11'h0F0, 11'h70F);

        // Single request, basic path.
        rv[2] = 1; rx[2] = 15'h1234; bus1.rsp_ready = 1'b1;
        settle();
        chk_val("basic req_ready", bus1.req_ready, 4'b0100);
        step();
        rv[2] = 0;
        settle();
        chk_val("basic pla_x", pla_x1, 15'h1234);
        chk_val("basic eval rsp_valid", bus1.rsp_valid, 0);
        step();
        settle();
        chk_val("basic rsp_valid", bus1.rsp_valid, 1);
        chk_val("basic rsp_id", bus1.rsp_id, 2);
        chk_val("basic rsp_z", bus1.rsp_z, 11'h234);
        step();
        settle();
        chk_val("basic done", bus1.rsp_valid, 0);
        drain();

        // Fairness: everyone valid, ids should rotate from 0 every 3 cycles.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin rv[i] = 1; rx[i] = 15'(i); end
        bus1.rsp_ready = 1'b1;
        nresp = 0; last = -1; exp_id = 0;
        for (int n = 0; n < 60 && nresp < 12; n++) begin
            settle();
            if (m_rspv) begin
                chk_val("fair id", bus1.rsp_id, exp_id % NREQ);
                chk_val("fair z", bus1.rsp_z, exp_id % NREQ);
                if (last >= 0) chk_val("fair spacing", cyc - last, 3);
                last = cyc; exp_id++; nresp++;
            end
            step();
        end
        chk_val("fair count", nresp, 12);
        clear_reqs();
        drain();

        // Backpressure: response held for 10 cycles while others wait.
        rv[1] = 1; rx[1] = 15'h2ABC; bus1.rsp_ready = 1'b0;
        step();
        rv[1] = 0;
        for (int n = 0; n < 10 && !m_rspv; n++) step();
        rv[0] = 1; rx[0] = 15'h0001; rv[3] = 1; rx[3] = 15'h0003;
        for (int n = 0; n < 10; n++) begin
            settle();
            chk_val("bp rsp_valid", bus1.rsp_valid, 1);
            chk_val("bp rsp_id", bus1.rsp_id, 1);
            chk_val("bp rsp_z", bus1.rsp_z, 11'h2BC);
            chk_val("bp pla_x", pla_x1, 15'h2ABC);
            chk_val("bp req_ready", bus1.req_ready, 0);
            chk_val("bp busy", busy1, 1);
            step();
        end
        bus1.rsp_ready = 1'b1;
        step();
        settle();
        chk_val("bp next grant", bus1.req_ready, 4'b1000);
        clear_reqs();
        drain();

        // Reset during EVAL, then during RESP.
        rv[3] = 1; rx[3] = 15'h0555; bus1.rsp_ready = 1'b0;
        step();
        do_reset();
        settle();
        chk_val("post-reset grant 3", bus1.req_ready, 4'b1000);
        step();
        step();
        settle();
        chk_val("resp before reset", bus1.rsp_valid, 1);
        do_reset();
        rv[0] = 1; rx[0] = 15'h0042;
        settle();
        chk_val("post-reset grant 0", bus1.req_ready, 4'b0001);
        step();
        clear_reqs();
        drain();

        // Dropped request: 1 and 2 raise while busy, 1 drops before IDLE.
        rv[0] = 1; rx[0] = 15'h0111; bus1.rsp_ready = 1'b1;
        step();
        rv[0] = 0;
        rv[1] = 1; rx[1] = 15'h0222; rv[2] = 1; rx[2] = 15'h0333;
        step();
        rv[1] = 0;
        step();
        settle();
        chk_val("drop grant 2", bus1.req_ready, 4'b0100);
        step();
        clear_reqs();
        drain();

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rv[i]) begin
                    if ($urandom_range(0, 15) == 0) rv[i] = 0;
                end else if ($urandom_range(0, 2) == 0) begin
                    rv[i] = 1;
                    rx[i] = 15'($urandom);
                end
            end
            bus1.rsp_ready = ($urandom_range(0, 9) < 7);
            step();
            if (m_hs >= 0) begin
                rv[m_hs] = 1'($urandom_range(0, 1));
                rx[m_hs] = 15'($urandom);
            end
        end
        clear_reqs();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
